// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch queue.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 1;

  // One reservation slot: the PC it was fetched from, the returned word,
  // and whether the word has come back yet.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
    logic            filled;
  } fetch_entry_t;

  // Bits needed to encode the values 0..n-1 (never less than one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fetch_rsv_buffer.sv
// In-order reservation ring: slots are allocated at request, filled at response, popped by decode.
// Latency: fill visible at head one cycle after the fill strobe.
// Backpressure: caller must not alloc when count==DEPTH, nor fill/pop an empty/unfilled slot.
module fetch_rsv_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = idx_width(DEPTH),
  localparam int CW = idx_width(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc,
  input  logic [XLEN-1:0]    alloc_pc,
  input  logic               fill,
  input  logic [XLEN-1:0]    fill_ir,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CW-1:0]      count,
  output logic [CW-1:0]      unfilled
);

  fetch_entry_t  ring [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] fill_ptr;

  assign head = ring[head_ptr];

  // Ring storage and the three wrapping pointers; flush only clears the filled flags
  // because stale pc/ir contents are invisible once filled is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      unfilled <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ring[i].filled <= 1'b0;
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) begin
        ring[tail_ptr].pc     <= alloc_pc;
        ring[tail_ptr].filled <= 1'b0;
        tail_ptr              <= tail_ptr + PW'(1);
      end
      if (fill) begin
        ring[fill_ptr].ir     <= fill_ir;
        ring[fill_ptr].filled <= 1'b1;
        fill_ptr              <= fill_ptr + PW'(1);
      end
      if (pop) begin
        ring[head_ptr].filled <= 1'b0;
        head_ptr              <= head_ptr + PW'(1);
      end
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues pipelined REQ/GNT requests and queues tagged instructions for decode.
// Latency: GNT at t, RVALID at t+k, IR_VALID at t+k+1.
// Backpressure: stops requesting when buffered + to-be-discarded responses reach DEPTH; decode stalls via IR_READY.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = fetch_pkg::PC_STEP
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            IR_VALID,
  input  logic            IR_READY,
  output logic [XLEN-1:0] IR,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] PC_M1
);

  localparam int              CW      = idx_width(DEPTH + 1);
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   unfilled;
  logic [CW:0]     occupancy;
  fetch_entry_t    head;
  logic            grant;
  logic            fill;
  logic            pop;
  logic            drop;

  fetch_rsv_buffer #(.DEPTH(DEPTH)) u_rsv (
    .clk      (CLOCK),
    .rst      (RESET),
    .flush    (REDIRECT),
    .alloc    (grant),
    .alloc_pc (fetch_pc),
    .fill     (fill),
    .fill_ir  (IMEM_RDATA),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .unfilled (unfilled)
  );

  assign IMEM_ADDR = fetch_pc;
  assign IR_VALID  = head.filled;
  assign IR        = head.ir;
  assign PC_OUT    = head.pc;
  assign PC_M1     = head.pc + STEP;

  // Issue gating and event decode; a slot stays reserved until its response is either
  // popped by decode or discarded after a redirect, so both count toward occupancy.
  always_comb begin
    occupancy = {1'b0, count} + {1'b0, drop_cnt};
    IMEM_REQ  = !RESET && !REDIRECT && (occupancy < DEPTH_W);
    grant     = IMEM_REQ && IMEM_GNT;
    drop      = IMEM_RVALID && (drop_cnt != '0);
    fill      = IMEM_RVALID && (drop_cnt == '0) && !REDIRECT;
    pop       = IR_VALID && IR_READY && !REDIRECT;
  end

  // Fetch PC: redirect wins, otherwise advance (wrapping) on each accepted request.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)         fetch_pc <= RESET_PC;
    else if (REDIRECT) fetch_pc <= REDIRECT_PC;
    else if (grant)    fetch_pc <= fetch_pc + STEP;
  end

  // Responses still owed by memory for flushed slots; any response arriving in the
  // redirect cycle is thrown away, whichever bucket it would have come from.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)         drop_cnt <= '0;
    else if (REDIRECT) drop_cnt <= drop_cnt + unfilled - CW'(IMEM_RVALID);
    else if (drop)     drop_cnt <= drop_cnt - CW'(1);
  end

  // Memory must never answer a request that was not issued.
  a_no_orphan_rvalid: assert property (@(posedge CLOCK) disable iff (RESET)
    IMEM_RVALID |-> ((drop_cnt != '0) || (unfilled != '0)));

  // Buffered plus pending-discard slots never exceed the ring size.
  a_occupancy_bound: assert property (@(posedge CLOCK) disable iff (RESET)
    occupancy <= DEPTH_W);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, hand-written corner sequences and random traffic.
// Memory is a latency-queue model; expected decode stream is derived from the fetch/redirect rules.
// Every cycle's outputs are compared against the reference model as well.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        IR_VALID;
  logic        IR_READY = 1'b0;
  logic [31:0] IR;
  logic [31:0] PC_OUT;
  logic [31:0] PC_M1;

  always #5 CLOCK = ~CLOCK;

  if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(1)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .IR_VALID(IR_VALID), .IR_READY(IR_READY), .IR(IR), .PC_OUT(PC_OUT), .PC_M1(PC_M1)
  );

  // Memory-side request in flight, and the decode-side view of one expected instruction.
  typedef struct { logic [31:0] pc; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; bit filled; } slot_t;
  typedef struct { bit rst; bit gnt; bit rdy; bit req; logic [31:0] addr; bit vld; logic [31:0] pc; } vec_t;

  mreq_t       memq[$];
  slot_t       live[$];
  logic [31:0] fetch_pc = '0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          errors = 0;
  int          checks = 0;
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_ir, s_pcm1;
  vec_t        vecs[14];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int stale_pending();
    int n = 0;
    for (int i = 0; i < memq.size(); i++) if (memq[i].stale) n++;
    return n;
  endfunction

  task automatic setv(input int i, input bit rst, input bit gnt, input bit rdy, input bit req,
                      input logic [31:0] addr, input bit vld, input logic [31:0] pc);
    vecs[i].rst = rst; vecs[i].gnt = gnt; vecs[i].rdy = rdy; vecs[i].req = req;
    vecs[i].addr = addr; vecs[i].vld = vld; vecs[i].pc = pc;
  endtask

  // Reset (optionally mid-cycle), check the asynchronous reset values, restart the model.
  task automatic do_reset(input bit mid);
    if (mid) #2;
    RESET = 1'b1;
    #1;
    chk1 ("rst_imem_req", IMEM_REQ, 1'b0);
    chk1 ("rst_ir_valid", IR_VALID, 1'b0);
    chk32("rst_ir", IR, 32'h0);
    chk32("rst_pc_out", PC_OUT, 32'h0);
    chk32("rst_pc_m1", PC_M1, 32'h1);
    memq.delete();
    live.delete();
    fetch_pc = 32'h0;
    IMEM_RVALID = 1'b0; IMEM_GNT = 1'b0; REDIRECT = 1'b0; IR_READY = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    cyc = 0;
  endtask

  // One clock cycle: drive, check against the model, then advance model and memory.
  task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit    rv, exp_req, exp_vld, grant, pop;
    int    occ;
    mreq_t m;
    slot_t s;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    IMEM_RVALID = rv;
    IMEM_RDATA  = rv ? mem_word(memq[0].pc) : 32'h0;
    IMEM_GNT = gnt; IR_READY = rdy; REDIRECT = redir; REDIRECT_PC = rpc;
    #1;
    s_req = IMEM_REQ; s_addr = IMEM_ADDR; s_vld = IR_VALID;
    s_pc = PC_OUT; s_ir = IR; s_pcm1 = PC_M1;
    occ = live.size() + stale_pending();
    exp_req = !redir && (occ < DEPTH);
    chk1("imem_req", s_req, exp_req);
    if (exp_req && s_req) chk32("imem_addr", s_addr, fetch_pc);
    exp_vld = (live.size() > 0) && live[0].filled;
    chk1("ir_valid", s_vld, exp_vld);
    if (exp_vld && s_vld) begin
      chk32("pc_out", s_pc, live[0].pc);
      chk32("ir", s_ir, mem_word(live[0].pc));
      chk32("pc_m1", s_pcm1, live[0].pc + 32'd1);
    end
    grant = s_req && gnt;
    pop   = s_vld && rdy && !redir;
    @(posedge CLOCK);
    if (rv) begin
      m = memq.pop_front();
      if (!redir && !m.stale) begin
        for (int i = 0; i < live.size(); i++) begin
          if (!live[i].filled) begin
            s = live[i]; s.filled = 1'b1; live[i] = s;
            break;
          end
        end
      end
    end
    if (pop && live.size() > 0) s = live.pop_front();
    if (grant) begin
      m.pc = s_addr;
      m.due = cyc + int'($urandom_range(lat_max, lat_min));
      m.stale = 1'b0;
      memq.push_back(m);
      s.pc = fetch_pc; s.filled = 1'b0;
      live.push_back(s);
      fetch_pc = fetch_pc + 32'd1;
    end
    if (redir) begin
      live.delete();
      for (int i = 0; i < memq.size(); i++) begin
        m = memq[i]; m.stale = 1'b1; memq[i] = m;
      end
      fetch_pc = rpc;
    end
    cyc++;
    chk1("outstanding_le_depth", memq.size() <= DEPTH, 1'b1);
    @(negedge CLOCK);
  endtask

  // Free-running fetch until the first instruction shows up; it must carry pc_exp.
  task automatic expect_first_pc(input string name, input logic [31:0] pc_exp, input int budget);
    bit found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (s_vld) begin
        found = 1'b1;
        chk32(name, s_pc, pc_exp);
      end
    end
    chk1({name, "_seen"}, found, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found, seen, prev_ff;
    // Latency-1 tables: streaming with decode always ready, then decode stalled.
    setv(0,  1, 1, 1, 1, 32'd0, 0, 32'd0);
    setv(1,  0, 1, 1, 1, 32'd1, 0, 32'd0);
    setv(2,  0, 1, 1, 1, 32'd2, 1, 32'd0);
    setv(3,  0, 1, 1, 1, 32'd3, 1, 32'd1);
    setv(4,  0, 1, 1, 1, 32'd4, 1, 32'd2);
    setv(5,  0, 1, 1, 1, 32'd5, 1, 32'd3);
    setv(6,  1, 1, 0, 1, 32'd0, 0, 32'd0);
    setv(7,  0, 1, 0, 1, 32'd1, 0, 32'd0);
    setv(8,  0, 1, 0, 1, 32'd2, 1, 32'd0);
    setv(9,  0, 1, 0, 1, 32'd3, 1, 32'd0);
    setv(10, 0, 1, 0, 0, 32'd0, 1, 32'd0);
    setv(11, 0, 1, 1, 0, 32'd0, 1, 32'd0);
    setv(12, 0, 1, 0, 1, 32'd4, 1, 32'd1);
    setv(13, 0, 1, 0, 0, 32'd0, 1, 32'd1);

    #3;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset(1'b0);
      step(vecs[i].gnt, vecs[i].rdy, 1'b0, 32'h0);
      chk1($sformatf("vec%0d_req", i), s_req, vecs[i].req);
      if (vecs[i].req) chk32($sformatf("vec%0d_addr", i), s_addr, vecs[i].addr);
      chk1($sformatf("vec%0d_vld", i), s_vld, vecs[i].vld);
      if (vecs[i].vld) chk32($sformatf("vec%0d_pc", i), s_pc, vecs[i].pc);
    end

    // Redirect with three requests in flight at latency 3.
    do_reset(1'b0);
    lat_min = 3; lat_max = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    expect_first_pc("t3_first_pc", 32'h100, 15);

    // Redirect coinciding with a response and a pop.
    do_reset(1'b0);
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && live.size() > 0 && live[0].filled) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk1("t4_setup", found, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("t4_empty", s_vld, 1'b0);
    chk1("t4_req", s_req, 1'b1);
    chk32("t4_addr", s_addr, 32'h40);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_first_pc("t4_first_pc", 32'h40, 4);

    // Back-to-back redirects with responses pending.
    do_reset(1'b0);
    lat_min = 3; lat_max = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h10);
    step(1'b1, 1'b1, 1'b1, 32'h20);
    expect_first_pc("t5_first_pc", 32'h20, 15);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space, then reset in the middle of the burst.
    do_reset(1'b0);
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    seen = 1'b0;
    prev_ff = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (prev_ff && s_req) chk32("t6_wrap_addr", s_addr, 32'h0);
      prev_ff = s_req && (s_addr == 32'hFFFF_FFFF);
      if (s_vld && s_pc == 32'hFFFF_FFFF) begin
        seen = 1'b1;
        chk32("t6_wrap_pc_m1", s_pcm1, 32'h0);
      end
    end
    chk1("t6_wrap_seen", seen, 1'b1);
    do_reset(1'b1);

    // Random traffic with variable memory latency, stalls and redirects.
    lat_min = 1; lat_max = 5;
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(99) < 70, $urandom_range(99) < 60, $urandom_range(99) < 4, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
